// File: rtl/core_pkg.sv
// Shared definitions for the core sequencer: instruction bit positions,
// the idle instruction word and the 3-bit FSM state encoding.
package core_pkg;

  localparam int INST_W = 35;
  localparam int A_W    = 11;

  localparam int B_MODE      = 34;
  localparam int B_ACC       = 33;
  localparam int B_CEN_PMEM  = 32;
  localparam int B_WEN_PMEM  = 31;
  localparam int B_A_PMEM_LO = 20;
  localparam int B_CEN_XMEM  = 19;
  localparam int B_WEN_XMEM  = 18;
  localparam int B_A_XMEM_LO = 7;
  localparam int B_OFIFO_RD  = 6;
  localparam int B_IFIFO_WR  = 5;
  localparam int B_IFIFO_RD  = 4;
  localparam int B_L0_RD     = 3;
  localparam int B_L0_WR     = 2;
  localparam int B_EXECUTE   = 1;
  localparam int B_LOAD      = 0;

  // Both SRAMs deselected with write disabled (CEN/WEN are active-low).
  localparam logic [INST_W-1:0] IDLE_INST = 35'h1_800C_0000;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WFET  = 3'd1;
  localparam logic [2:0] ST_WLOAD = 3'd2;
  localparam logic [2:0] ST_AFET  = 3'd3;
  localparam logic [2:0] ST_EXEC  = 3'd4;
  localparam logic [2:0] ST_DRAIN = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;

endpackage

// File: rtl/xmem_fetcher.sv
// Issues n sequential xMem reads from a base address and produces the
// l0_wr strobe one cycle behind each read (1-cycle SRAM latency).
module xmem_fetcher
  import core_pkg::*;
#(
  parameter int ADDR_BW = A_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_BW-1:0] base,
  input  logic [ADDR_BW-1:0] n,
  output logic               rd_en,
  output logic [ADDR_BW-1:0] rd_addr,
  output logic               l0_wr,
  output logic               last_wr
);

  localparam logic [ADDR_BW-1:0] ONE = ADDR_BW'(1);

  logic               active_q, active_d;
  logic               pend_q, pend_d;
  logic [ADDR_BW-1:0] cnt_q, cnt_d;
  logic [ADDR_BW-1:0] base_q, base_d;
  logic [ADDR_BW-1:0] last_q, last_d;

  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    base_d   = base_q;
    last_d   = last_q;
    pend_d   = active_q;
    if (start && (n != '0)) begin
      active_d = 1'b1;
      cnt_d    = '0;
      base_d   = base;
      last_d   = n - ONE;
    end else if (active_q) begin
      cnt_d = cnt_q + ONE;
      if (cnt_q == last_q) active_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q <= 1'b0;
      pend_q   <= 1'b0;
      cnt_q    <= '0;
      base_q   <= '0;
      last_q   <= '0;
    end else begin
      active_q <= active_d;
      pend_q   <= pend_d;
      cnt_q    <= cnt_d;
      base_q   <= base_d;
      last_q   <= last_d;
    end
  end

  // Address wraps silently modulo 2^ADDR_BW.
  assign rd_en   = active_q;
  assign rd_addr = base_q + cnt_q;
  assign l0_wr   = pend_q;
  assign last_wr = pend_q & ~active_q;

endmodule

// File: rtl/core_sequencer.sv
// Tile sequencer for the weight-stationary core: weight fetch, kernel load,
// activation fetch, execute and OFIFO drain into PSUM memory.
module core_sequencer
  import core_pkg::*;
#(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int addr_bw = 11,
  parameter int flush   = row + col
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               cfg_mode,
  input  logic               cfg_acc,
  input  logic [addr_bw-1:0] cfg_wbase,
  input  logic [addr_bw-1:0] cfg_abase,
  input  logic [addr_bw-1:0] cfg_pbase,
  input  logic [addr_bw-1:0] cfg_n_act,
  input  logic               valid,
  output logic [INST_W-1:0]  inst,
  output logic               busy,
  output logic               done,
  output logic [2:0]         dbg_state
);

  localparam int CW = addr_bw + 1;
  localparam logic [CW-1:0]      CNT_ONE    = CW'(1);
  localparam logic [CW-1:0]      COL_C      = CW'(col);
  localparam logic [CW-1:0]      WLOAD_LAST = CW'(col + flush - 1);
  localparam logic [CW-1:0]      FLUSH_M1   = CW'(flush - 1);
  localparam logic [addr_bw-1:0] COL_A      = addr_bw'(col);
  localparam logic [addr_bw-1:0] A_ONE      = addr_bw'(1);

  logic [2:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [addr_bw-1:0] rd_cnt_q, rd_cnt_d;
  logic [addr_bw-1:0] wr_cnt_q, wr_cnt_d;
  logic               wr_pend_q, wr_pend_d;
  logic [addr_bw-1:0] abase_q, abase_d;
  logic [addr_bw-1:0] pbase_q, pbase_d;
  logic [addr_bw-1:0] n_act_q, n_act_d;
  logic               mode_q, mode_d;
  logic               acc_q, acc_d;
  logic [INST_W-1:0]  inst_q, inst_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               fetch_start;
  logic [addr_bw-1:0] fetch_base, fetch_n;
  logic               fetch_rd, fetch_l0_wr, fetch_last;
  logic [addr_bw-1:0] fetch_addr;
  logic               ofifo_rd;
  logic [CW-1:0]      n_ext;

  assign n_ext = {1'b0, n_act_q};

  xmem_fetcher #(.ADDR_BW(addr_bw)) u_fetch (
    .clk     (clk),
    .reset   (reset),
    .start   (fetch_start),
    .base    (fetch_base),
    .n       (fetch_n),
    .rd_en   (fetch_rd),
    .rd_addr (fetch_addr),
    .l0_wr   (fetch_l0_wr),
    .last_wr (fetch_last)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_cnt_d    = rd_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    wr_pend_d   = 1'b0;
    abase_d     = abase_q;
    pbase_d     = pbase_q;
    n_act_d     = n_act_q;
    mode_d      = mode_q;
    acc_d       = acc_q;
    fetch_start = 1'b0;
    fetch_base  = abase_q;
    fetch_n     = n_act_q;
    ofifo_rd    = 1'b0;
    inst_d      = IDLE_INST;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_WFET;
          abase_d     = cfg_abase;
          pbase_d     = cfg_pbase;
          n_act_d     = cfg_n_act;
          mode_d      = cfg_mode;
          acc_d       = cfg_acc;
          fetch_start = 1'b1;
          fetch_base  = cfg_wbase;
          fetch_n     = COL_A;
        end
      end
      ST_WFET: begin
        if (fetch_last) begin
          state_d = ST_WLOAD;
          cnt_d   = '0;
        end
      end
      ST_WLOAD: begin
        if (cnt_q < COL_C) begin
          inst_d[B_L0_RD] = 1'b1;
          inst_d[B_LOAD]  = 1'b1;
        end
        if (cnt_q == WLOAD_LAST) begin
          cnt_d = '0;
          if (n_act_q == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d     = ST_AFET;
            fetch_start = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_AFET: begin
        if (fetch_last) begin
          state_d = ST_EXEC;
          cnt_d   = '0;
        end
      end
      ST_EXEC: begin
        if (cnt_q < n_ext) begin
          inst_d[B_L0_RD]   = 1'b1;
          inst_d[B_EXECUTE] = 1'b1;
        end
        if (cnt_q == n_ext + FLUSH_M1) begin
          state_d  = ST_DRAIN;
          cnt_d    = '0;
          rd_cnt_d = '0;
          wr_cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_DRAIN: begin
        // Each OFIFO read is followed one cycle later by its PSUM write.
        ofifo_rd  = valid && (rd_cnt_q < n_act_q);
        wr_pend_d = ofifo_rd;
        if (ofifo_rd) rd_cnt_d = rd_cnt_q + A_ONE;
        inst_d[B_OFIFO_RD] = ofifo_rd;
        if (wr_pend_q) begin
          inst_d[B_CEN_PMEM]                 = 1'b0;
          inst_d[B_WEN_PMEM]                 = 1'b0;
          inst_d[B_A_PMEM_LO +: addr_bw]     = pbase_q + wr_cnt_q;
          inst_d[B_ACC]                      = acc_q;
          wr_cnt_d                           = wr_cnt_q + A_ONE;
        end else if (wr_cnt_q == n_act_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (fetch_rd) begin
      inst_d[B_CEN_XMEM]             = 1'b0;
      inst_d[B_A_XMEM_LO +: addr_bw] = fetch_addr;
    end
    if (fetch_l0_wr) inst_d[B_L0_WR] = 1'b1;

    busy_d         = (state_q == ST_IDLE) ? start : (state_q != ST_DONE);
    done_d         = (state_q == ST_DONE);
    inst_d[B_MODE] = busy_d & mode_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      wr_pend_q <= 1'b0;
      abase_q   <= '0;
      pbase_q   <= '0;
      n_act_q   <= '0;
      mode_q    <= 1'b0;
      acc_q     <= 1'b0;
      inst_q    <= IDLE_INST;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      wr_pend_q <= wr_pend_d;
      abase_q   <= abase_d;
      pbase_q   <= pbase_d;
      n_act_q   <= n_act_d;
      mode_q    <= mode_d;
      acc_q     <= acc_d;
      inst_q    <= inst_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign inst      = inst_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Randomized tile-level bench for core_sequencer: expected xMem/PSUM address
// streams and per-tile strobe counts are queued at start and checked by a monitor.
module tb_core_sequencer;

  localparam int COL   = 8;
  localparam int FLUSH = 16;
  // CEN_pmem, WEN_pmem, CEN_xmem, WEN_xmem set; everything else clear.
  localparam logic [34:0] IDLE_EXP = 35'h1_800C_0000;

  typedef struct {
    logic mode;
    logic acc;
    int   n_act;
    int   vmode;
  } tile_t;

  logic        clk = 1'b0;
  logic        reset, start, cfg_mode, cfg_acc, valid;
  logic [10:0] cfg_wbase, cfg_abase, cfg_pbase, cfg_n_act;
  logic [34:0] inst;
  logic        busy, done;
  logic [2:0]  dbg_state;

  core_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .cfg_mode  (cfg_mode),
    .cfg_acc   (cfg_acc),
    .cfg_wbase (cfg_wbase),
    .cfg_abase (cfg_abase),
    .cfg_pbase (cfg_pbase),
    .cfg_n_act (cfg_n_act),
    .valid     (valid),
    .inst      (inst),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [10:0] exp_x_q[$];
  logic [10:0] exp_p_q[$];
  tile_t       tile_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0d (0x%0h) expected=%0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // ---------------- valid driver ----------------
  int vmode = 0;  // 0 tied high, 1 toggling, 2 random
  initial begin
    valid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (vmode)
        0:       valid = 1'b1;
        1:       valid = ~valid;
        default: valid = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int    cyc = 0, loads = 0, execs = 0, rds = 0, wrs = 0, dones = 0;
  int    last_load = 0, last_exec = 0;
  logic  prev_xrd = 0, prev_rd = 0, prev_valid = 0;
  logic  first_act_seen = 0, first_rd_seen = 0;
  logic  xrd;
  tile_t cur;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      loads = 0; execs = 0; rds = 0; wrs = 0;
      prev_xrd = 0; prev_rd = 0; prev_valid = 0;
      first_act_seen = 0; first_rd_seen = 0;
    end else begin
      xrd = ~inst[19];
      if (xrd) begin
        check("wen_xmem", inst[18], 1);
        if (exp_x_q.size() == 0) check("xmem_extra_read", 1, 0);
        else check("a_xmem", inst[17:7], exp_x_q.pop_front());
        if (loads == COL && !first_act_seen) begin
          first_act_seen = 1;
          check("wload_flush_gap", cyc - last_load, FLUSH + 1);
        end
      end
      if (inst[2] || prev_xrd) check("l0_wr_lag", inst[2], prev_xrd);
      if (inst[0]) begin
        check("load_l0_rd", inst[3], 1);
        loads++;
        last_load = cyc;
      end
      if (inst[1]) begin
        check("exec_l0_rd", inst[3], 1);
        execs++;
        last_exec = cyc;
      end
      if (inst[6]) begin
        check("ofifo_rd_needs_valid", prev_valid, 1);
        rds++;
        if (!first_rd_seen && tile_q.size() > 0 && tile_q[0].vmode == 0)
          check("exec_flush_gap", cyc - last_exec, FLUSH + 1);
        first_rd_seen = 1;
      end
      if (!inst[32]) begin
        check("wen_pmem", inst[31], 0);
        check("psum_after_rd", prev_rd, 1);
        if (tile_q.size() > 0) check("acc_bit", inst[33], tile_q[0].acc);
        if (exp_p_q.size() == 0) check("psum_extra_write", 1, 0);
        else check("a_pmem", inst[30:20], exp_p_q.pop_front());
        wrs++;
      end
      if (busy && tile_q.size() > 0) check("mode_bit", inst[34], tile_q[0].mode);
      if (!busy) check("idle_inst", inst, IDLE_EXP);
      if (done) begin
        check("busy_low_at_done", busy, 0);
        if (tile_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          cur = tile_q.pop_front();
          check("load_count", loads, COL);
          check("exec_count", execs, cur.n_act);
          check("ofifo_rd_count", rds, cur.n_act);
          check("psum_write_count", wrs, cur.n_act);
          check("xmem_reads_left", exp_x_q.size(), 0);
          if (cur.n_act == 0) check("wload_to_done_gap", cyc - last_load, FLUSH + 1);
        end
        dones++;
        loads = 0; execs = 0; rds = 0; wrs = 0;
        first_act_seen = 0; first_rd_seen = 0;
      end
      prev_xrd   = xrd;
      prev_rd    = inst[6];
      prev_valid = valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_model(input logic [10:0] wb, ab, pb, n, input logic m, a, input int vm);
    tile_t t;
    for (int k = 0; k < COL; k++) exp_x_q.push_back(11'((int'(wb) + k) % 2048));
    for (int k = 0; k < int'(n); k++) exp_x_q.push_back(11'((int'(ab) + k) % 2048));
    for (int k = 0; k < int'(n); k++) exp_p_q.push_back(11'((int'(pb) + k) % 2048));
    t.mode = m; t.acc = a; t.n_act = int'(n); t.vmode = vm;
    tile_q.push_back(t);
  endtask

  task automatic issue_start(input logic [10:0] wb, ab, pb, n, input logic m, a, input int vm);
    vmode = vm;
    @(posedge clk); #1;
    cfg_wbase = wb; cfg_abase = ab; cfg_pbase = pb; cfg_n_act = n;
    cfg_mode = m; cfg_acc = a; start = 1'b1;
    push_model(wb, ab, pb, n, m, a, vm);
    @(posedge clk); #1;
    start = 1'b0;
    cfg_wbase = 11'($urandom); cfg_abase = 11'($urandom); cfg_pbase = 11'($urandom);
    cfg_n_act = 11'($urandom_range(0, 20)); cfg_mode = ~m; cfg_acc = ~a;
  endtask

  task automatic wait_done();
    int d0 = dones;
    for (int i = 0; i < 5000 && dones == d0; i++) @(posedge clk);
    check("done_within_budget", dones != d0, 1);
  endtask

  task automatic run_tile(input logic [10:0] wb, ab, pb, n, input logic m, a, input int vm,
                          input bit poke);
    issue_start(wb, ab, pb, n, m, a, vm);
    if (poke) begin
      repeat (3) @(posedge clk);
      #1;
      cfg_wbase = 11'($urandom); cfg_n_act = 11'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    wait_done();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int d0;
    reset = 1'b1; start = 1'b0; cfg_mode = 0; cfg_acc = 0;
    cfg_wbase = '0; cfg_abase = '0; cfg_pbase = '0; cfg_n_act = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_inst", inst, IDLE_EXP);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    run_tile(11'd0, 11'd0, 11'd0, 11'd0, 1'b1, 1'b0, 0, 0);        // weights only
    run_tile(11'd0, 11'd16, 11'd100, 11'd4, 1'b1, 1'b1, 0, 0);     // full tile, valid high
    run_tile(11'd0, 11'd16, 11'd100, 11'd4, 1'b0, 1'b1, 1, 0);     // valid toggling
    run_tile(11'd5, 11'd2046, 11'd7, 11'd4, 1'b1, 1'b0, 0, 0);     // xMem address wrap
    run_tile(11'd2044, 11'd30, 11'd2045, 11'd6, 1'b1, 1'b1, 2, 1); // PSUM wrap, start while busy

    // Abort mid-EXEC: no done, outputs idle on the next cycle.
    issue_start(11'd40, 11'd60, 11'd200, 11'd6, 1'b1, 1'b1, 0);
    for (int i = 0; i < 2000 && execs < 2; i++) @(posedge clk);
    check("reached_exec", execs >= 2, 1);
    #1;
    d0 = dones;
    reset = 1'b1;
    exp_x_q.delete(); exp_p_q.delete(); tile_q.delete();
    @(posedge clk); #1;
    check("abort_inst", inst, IDLE_EXP);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    reset = 1'b0;
    repeat (40) @(posedge clk);
    check("no_done_after_abort", dones, d0);
    run_tile(11'd3, 11'd9, 11'd50, 11'd3, 1'b0, 1'b0, 0, 0);

    for (int t = 0; t < 6; t++)
      run_tile(11'($urandom), 11'($urandom), 11'($urandom), 11'($urandom_range(0, 12)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 2),
               bit'($urandom_range(0, 1)));

    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
